// File: rtl/enc_gray_codec.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : enc_gray_codec
// Brief    : Pipelined binary<->Gray converter with valid/ready handshakes.
//            Optional Gray step checker enabled by GRAY_STEP_CHECK_EN.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module enc_gray_codec #(
    parameter int WIDTH  = 10,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [WIDTH-1:0] out_data,
    output logic             step_err
);

    logic [STAGES-1:0]             r_valid;
    logic [STAGES-1:0]             r_mode;
    logic [STAGES-1:0]             r_err;
    logic [STAGES-1:0][WIDTH-1:0]  r_data;
    logic [STAGES-1:0]             w_load;
    logic [WIDTH-1:0]              w_gray;
    logic [WIDTH-1:0]              w_bin;
    logic [WIDTH-1:0]              w_conv;
    logic                          w_accept;
    logic                          w_err;

    assign w_gray = in_data ^ (in_data >> 1);

    // Each binary bit is the XOR of all Gray bits at or above it.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_g2b
            assign w_bin[i] = ^in_data[WIDTH-1:i];
        end
    endgenerate

    assign w_conv = in_mode ? w_bin : w_gray;

    // A stage is blocked only when it and every stage after it hold data
    // and the consumer is stalling.
    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_load
            assign w_load[k] = out_ready || !(&r_valid[STAGES-1:k]);
        end
    endgenerate

    assign in_ready = rst_n && w_load[0];
    assign w_accept = in_valid && in_ready;

`ifdef GRAY_STEP_CHECK_EN
    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_prev_gray;
    logic             r_have_prev;
    logic [WIDTH-1:0] w_gray_dom;
    logic [WIDTH-1:0] w_diff;

    assign w_gray_dom = in_mode ? in_data : w_gray;
    assign w_diff     = w_gray_dom ^ r_prev_gray;
    // Exactly one differing bit is the only legal step; zero is a repeat.
    assign w_err      = r_have_prev && !((w_diff != '0) && ((w_diff & (w_diff - C_ONE)) == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_gray <= '0;
            r_have_prev <= 1'b0;
        end else if (w_accept) begin
            r_prev_gray <= w_gray_dom;
            r_have_prev <= 1'b1;
        end
    end
`else
    assign w_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_mode  <= '0;
            r_err   <= '0;
            r_data  <= '0;
        end else begin
            if (w_load[0]) begin
                r_valid[0] <= w_accept;
                if (w_accept) begin
                    r_data[0] <= w_conv;
                    r_mode[0] <= in_mode;
                    r_err[0]  <= w_err;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= r_valid[k-1];
                    if (r_valid[k-1]) begin
                        r_data[k] <= r_data[k-1];
                        r_mode[k] <= r_mode[k-1];
                        r_err[k]  <= r_err[k-1];
                    end
                end
            end
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign out_data  = r_data[STAGES-1];
    assign out_mode  = r_mode[STAGES-1];
    assign step_err  = r_err[STAGES-1];

endmodule
`default_nettype wire
